interrupt_unit: RTL

INTERRUPT_UNIT -- requirements
Module: interrupt_unit

---
 rtl/interrupt_unit.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/interrupt_unit.sv
// interrupt_unit: four maskable edge-triggered interrupt sources plus one
// non-maskable source, fronting a CPU controller through a request/ack FSM.
//
// Ports
//   clk           in   sole clock, rising edge
//   rst_n         in   synchronous active-low reset
//   irq[3:0]      in   maskable request levels; rising edge requests, bit 0 highest
//   nmiIn         in   non-maskable request; rising edge requests
//   maskWrite     in   load maskData into the mask register
//   maskData[3:0] in   new enable mask, 1 = enabled
//   isInterrupted in   controller acknowledge
//   INA           in   ack type: 1 = maskable taken, 0 = NMI taken
//   iret          in   return-from-handler pulse
//   INT           out  maskable request (level until acknowledged)
//   NMI           out  non-maskable request (level until acknowledged)
//   INTD          out  maskable interrupts disabled (handler active)
//   cause[2:0]    out  last taken source: 0-3 irq index, 4 NMI
//   pending[3:0]  out  maskable pending bits
//
// Build option: define IRQ_SYNC_EN to put a two-flop synchroniser on irq and
// nmiIn ahead of edge detection (edge-to-request latency 3 cycles instead of 1).
module interrupt_unit (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] irq,
    input  logic       nmiIn,
    input  logic       maskWrite,
    input  logic [3:0] maskData,
    input  logic       isInterrupted,
    input  logic       INA,
    input  logic       iret,
    output logic       INT,
    output logic       NMI,
    output logic       INTD,
    output logic [2:0] cause,
    output logic [3:0] pending
);

    typedef enum logic [2:0] {StIdle, StIntReq, StNmiReq, StInInt, StInNmi} state_e;

    state_e     r_state, w_state_d;
    logic [3:0] r_mask, r_pending, r_irq_prev;
    logic       r_nmi_pend, r_nmi_prev, r_nested, w_nested_d;
    logic [2:0] r_cause, w_cause_d;

    logic [3:0] w_irq, w_irq_rise, w_pend_clr, w_pend_d, w_mask_keep, w_top_onehot;
    logic       w_nmi, w_nmi_rise, w_nmi_pend_d, w_ack_int, w_ack_nmi;
    logic [1:0] w_top_idx;

`ifdef IRQ_SYNC_EN
    logic [3:0] r_irq_s1, r_irq_s2;
    logic       r_nmi_s1, r_nmi_s2;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_irq_s1 <= 4'b0000;
            r_irq_s2 <= 4'b0000;
            r_nmi_s1 <= 1'b0;
            r_nmi_s2 <= 1'b0;
        end else begin
            r_irq_s1 <= irq;
            r_irq_s2 <= r_irq_s1;
            r_nmi_s1 <= nmiIn;
            r_nmi_s2 <= r_nmi_s1;
        end
    end

    assign w_irq = r_irq_s2;
    assign w_nmi = r_nmi_s2;
`else
    assign w_irq = irq;
    assign w_nmi = nmiIn;
`endif

    assign w_irq_rise = w_irq & ~r_irq_prev;
    assign w_nmi_rise = w_nmi & ~r_nmi_prev;

    // Lowest set index wins.
    always_comb begin
        w_top_idx = 2'd0;
        if (r_pending[0])      w_top_idx = 2'd0;
        else if (r_pending[1]) w_top_idx = 2'd1;
        else if (r_pending[2]) w_top_idx = 2'd2;
        else if (r_pending[3]) w_top_idx = 2'd3;
    end
    assign w_top_onehot = 4'b0001 << w_top_idx;

    // An ack only counts when its type matches a live request.
    assign w_ack_int = isInterrupted & INA & (r_state == StIntReq) & (|r_pending);
    assign w_ack_nmi = isInterrupted & ~INA & r_nmi_pend
                     & ((r_state == StIntReq) | (r_state == StNmiReq));

    // Ack clears first, then new edges set (gated by the pre-write mask), then a
    // mask write drops any bit it disables.
    assign w_pend_clr   = w_ack_int ? w_top_onehot : 4'b0000;
    assign w_mask_keep  = maskWrite ? maskData : 4'b1111;
    assign w_pend_d     = ((r_pending & ~w_pend_clr) | (w_irq_rise & r_mask)) & w_mask_keep;
    assign w_nmi_pend_d = (r_nmi_pend & ~w_ack_nmi) | w_nmi_rise;

    always_comb begin
        w_state_d  = r_state;
        w_nested_d = r_nested;
        w_cause_d  = r_cause;
        unique case (r_state)
            // Looks at next-state pending so a registered edge raises the request
            // on the same clock.
            StIdle: begin
                if (w_nmi_pend_d)     w_state_d = StNmiReq;
                else if (|w_pend_d)   w_state_d = StIntReq;
            end
            StIntReq: begin
                if (w_ack_int) begin
                    w_state_d = StInInt;
                    w_cause_d = {1'b0, w_top_idx};
                end else if (w_ack_nmi) begin
                    w_state_d = StInNmi;
                    w_cause_d = 3'd4;
                end else if (w_pend_d == 4'b0000) begin
                    w_state_d = StIdle;
                end
            end
            StNmiReq: begin
                if (w_ack_nmi) begin
                    w_state_d = StInNmi;
                    w_cause_d = 3'd4;
                end
            end
            // iret wins over a pending NMI: the handler has finished, and the NMI
            // is then raised un-nested from IDLE.
            StInInt: begin
                if (iret) begin
                    w_state_d = StIdle;
                end else if (r_nmi_pend) begin
                    w_state_d  = StNmiReq;
                    w_nested_d = 1'b1;
                end
            end
            StInNmi: begin
                if (iret) begin
                    if (r_nested) begin
                        w_state_d  = StInInt;
                        w_nested_d = 1'b0;
                    end else begin
                        w_state_d = StIdle;
                    end
                end
            end
            default: w_state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= StIdle;
            r_mask     <= 4'b0000;
            r_pending  <= 4'b0000;
            r_irq_prev <= 4'b0000;
            r_nmi_pend <= 1'b0;
            r_nmi_prev <= 1'b0;
            r_nested   <= 1'b0;
            r_cause    <= 3'd0;
        end else begin
            r_state    <= w_state_d;
            r_mask     <= maskWrite ? maskData : r_mask;
            r_pending  <= w_pend_d;
            r_irq_prev <= w_irq;
            r_nmi_pend <= w_nmi_pend_d;
            r_nmi_prev <= w_nmi;
            r_nested   <= w_nested_d;
            r_cause    <= w_cause_d;
        end
    end

    // Outputs are forced low while rst_n is held, not just after the reset edge.
    assign INT     = rst_n & (r_state == StIntReq);
    assign NMI     = rst_n & r_nmi_pend & (r_state != StInNmi);
    assign INTD    = rst_n & ((r_state == StInInt) | (r_state == StInNmi)
                            | ((r_state == StNmiReq) & r_nested));
    assign cause   = rst_n ? r_cause : 3'd0;
    assign pending = rst_n ? r_pending : 4'b0000;

endmodule
